// File: rtl/pipeline_pkg.sv
// Shared EX-stage definitions: R-type funct codes served by the mul/div unit and its FSM states.
package pipeline_pkg;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_e;
endpackage

// File: rtl/muldiv_iter_dp.sv
// One-bit-per-cycle shift/add multiply and restoring divide datapath on unsigned magnitudes.
// {acc,quo} holds the product, or remainder/quotient, once WIDTH steps have run.
module muldiv_iter_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step_mul,
  input  logic             step_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo
);
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign add_sum = {1'b0, acc} + (quo[0] ? {1'b0, b} : '0);
  assign rem_sh  = {acc, quo[WIDTH-1]};
  // A successful trial subtract always leaves a result below the divisor, so WIDTH bits suffice.
  assign borrow  = rem_sh < {1'b0, b};
  assign diff    = rem_sh[WIDTH-1:0] - b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      quo <= '0;
      b   <= '0;
    end else if (load) begin
      acc <= '0;
      quo <= op_a;
      b   <= op_b;
    end else if (step_mul) begin
      acc <= add_sum[WIDTH:1];
      quo <= {add_sum[0], quo[WIDTH-1:1]};
    end else if (step_div) begin
      acc <= borrow ? rem_sh[WIDTH-1:0] : diff;
      quo <= {quo[WIDTH-2:0], ~borrow};
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative MULT/DIV unit owning HI/LO; stalls the pipe only when an HI/LO op meets a busy unit.
module ex_muldiv_unit
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_rs,
  input  logic [WIDTH-1:0] in_rt,
  input  logic             flush,
  output logic             stall_req,
  output logic [WIDTH-1:0] mf_data,
  output logic             mf_valid,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             neg_res, neg_rem, div0, op_div;
  logic [WIDTH-1:0] rs_raw;
  logic [WIDTH-1:0] acc, quo;

  logic is_mf, is_mt, is_mul, is_div, is_signed, hilo_op, accept;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign is_mf     = (in_funct == FUNCT_MFHI) || (in_funct == FUNCT_MFLO);
  assign is_mt     = (in_funct == FUNCT_MTHI) || (in_funct == FUNCT_MTLO);
  assign is_mul    = (in_funct == FUNCT_MULT) || (in_funct == FUNCT_MULTU);
  assign is_div    = (in_funct == FUNCT_DIV)  || (in_funct == FUNCT_DIVU);
  assign is_signed = (in_funct == FUNCT_MULT) || (in_funct == FUNCT_DIV);
  assign hilo_op   = in_valid && !flush && (is_mf || is_mt || is_mul || is_div);

  assign busy      = (state != IDLE);
  assign stall_req = hilo_op && busy;
  assign accept    = hilo_op && !busy;
  assign mf_valid  = accept && is_mf;
  assign mf_data   = !mf_valid ? '0 : (in_funct == FUNCT_MFHI) ? hi : lo;

  assign rs_abs = (is_signed && in_rs[WIDTH-1]) ? -in_rs : in_rs;
  assign rt_abs = (is_signed && in_rt[WIDTH-1]) ? -in_rt : in_rt;

  // Sign correction applied at FIX; the most negative value wraps back onto itself.
  assign prod_fix = neg_res ? -{acc, quo} : {acc, quo};
  assign quo_fix  = neg_res ? -quo : quo;
  assign rem_fix  = neg_rem ? -acc : acc;

  muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && (is_mul || is_div)),
    .step_mul (state == MUL),
    .step_div (state == DIV),
    .op_a     (rs_abs),
    .op_b     (rt_abs),
    .acc      (acc),
    .quo      (quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      op_div  <= 1'b0;
      rs_raw  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (in_funct == FUNCT_MTHI) hi <= in_rs;
          if (in_funct == FUNCT_MTLO) lo <= in_rs;
          if (is_mul || is_div) begin
            state   <= is_mul ? MUL : DIV;
            cnt     <= '0;
            neg_res <= is_signed && (in_rs[WIDTH-1] ^ in_rt[WIDTH-1]);
            neg_rem <= is_signed && in_rs[WIDTH-1];
            div0    <= is_div && (in_rt == '0);
            op_div  <= is_div;
            rs_raw  <= in_rs;
          end
        end
        MUL, DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          if (!op_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (div0) begin
            hi <= rs_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
